// File: rtl/dmem_lsu_pkg.sv
// Shared encodings for the MIPS32 MEM-stage load/store unit: access sizes,
// controller states and the memory word size in bytes.
package dmem_lsu_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   localparam int unsigned WORD_BYTES = 4;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOAD   = 3'd1,
      STORE  = 3'd2,
      RMW_RD = 3'd3,
      RMW_WR = 3'd4,
      ERR    = 3'd5
   } state_e;

endpackage

// File: rtl/dmem_lsu_lane.sv
// Combinational byte-lane steering: MERGE=0 extracts and extends a load lane,
// MERGE=1 merges new store data into an old word (little-endian lanes).
module dmem_lsu_lane
   import dmem_lsu_pkg::*;
#(
   parameter bit MERGE = 1'b0
) (
   input  logic [1:0]  offset_i,
   input  logic [1:0]  size_i,
   input  logic        signed_i,
   input  logic [31:0] word_i,
   input  logic [31:0] data_i,
   output logic [31:0] result_o
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;
   logic [31:0] loaded;
   logic [31:0] merged;

   always_comb begin
      byte_sel = word_i[{offset_i, 3'b000} +: 8];
      half_sel = word_i[{offset_i[1], 4'b0000} +: 16];
      loaded   = word_i;
      merged   = data_i;
      case (size_i)
         SZ_BYTE: begin
            loaded = {{24{signed_i & byte_sel[7]}}, byte_sel};
            merged = word_i;
            merged[{offset_i, 3'b000} +: 8] = data_i[7:0];
         end
         SZ_HALF: begin
            loaded = {{16{signed_i & half_sel[15]}}, half_sel};
            merged = word_i;
            merged[{offset_i[1], 4'b0000} +: 16] = data_i[15:0];
         end
         default: begin
            loaded = word_i;
            merged = data_i;
         end
      endcase
      result_o = MERGE ? merged : loaded;
   end

endmodule

// File: rtl/dmem_lsu.sv
// Load/store unit converting byte/half/word pipeline accesses into word-only
// dmem accesses. Define DMEM_LSU_MISALIGN_TRAP_EN to trap misaligned accesses.
module dmem_lsu
   import dmem_lsu_pkg::*;
#(
   parameter int unsigned MEM_WORDS = 64,
   parameter int unsigned DATA_W    = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [1:0]        req_size,
   input  logic              req_signed,
   input  logic [31:0]       req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              resp_valid,
   output logic [DATA_W-1:0] resp_rdata,
   output logic              resp_err,
   output logic              stall,
   output logic              mem_we,
   output logic [31:0]       mem_a,
   output logic [DATA_W-1:0] mem_wd,
   input  logic [DATA_W-1:0] mem_rd
);

   if (DATA_W != 32) begin : g_width_chk
      $error("dmem_lsu supports only DATA_W = 32");
   end

   localparam logic [31:0] ADDR_LIMIT = 32'(WORD_BYTES * MEM_WORDS);

   state_e      state_q, state_d;
   logic        op_we_q, op_we_d;
   logic [1:0]  op_size_q, op_size_d;
   logic        op_signed_q, op_signed_d;
   logic [31:0] op_addr_q, op_addr_d;
   logic [31:0] op_wdata_q, op_wdata_d;
   logic [31:0] wbuf_q, wbuf_d;
   logic        resp_valid_q, resp_valid_d;
   logic [31:0] resp_rdata_q, resp_rdata_d;
   logic        resp_err_q, resp_err_d;

   logic        accept;
   logic        misalign;
   logic        req_bad;
   logic [1:0]  lane_off;
   logic [31:0] aligned_a;
   logic [31:0] load_data;
   logic [31:0] merge_data;

`ifdef DMEM_LSU_MISALIGN_TRAP_EN
   assign misalign = ((req_size == SZ_HALF) && req_addr[0]) ||
                     ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));
`else
   assign misalign = 1'b0;
`endif

   assign req_ready = (state_q == IDLE);
   assign stall     = ~req_ready;
   assign accept    = req_valid && req_ready;
   assign req_bad   = (req_size == 2'b11) || (req_addr >= ADDR_LIMIT) || misalign;
   assign aligned_a = {op_addr_q[31:2], 2'b00};

   // Misaligned low bits are truncated here; in the trapping build they never reach this point.
   always_comb begin
      case (op_size_q)
         SZ_BYTE: lane_off = op_addr_q[1:0];
         SZ_HALF: lane_off = {op_addr_q[1], 1'b0};
         default: lane_off = 2'b00;
      endcase
   end

   dmem_lsu_lane #(.MERGE(1'b0)) u_load_lane (
      .offset_i (lane_off),
      .size_i   (op_size_q),
      .signed_i (op_signed_q),
      .word_i   (mem_rd),
      .data_i   (32'h0),
      .result_o (load_data)
   );

   dmem_lsu_lane #(.MERGE(1'b1)) u_store_lane (
      .offset_i (lane_off),
      .size_i   (op_size_q),
      .signed_i (1'b0),
      .word_i   (mem_rd),
      .data_i   (op_wdata_q),
      .result_o (merge_data)
   );

   always_comb begin
      state_d      = state_q;
      op_we_d      = op_we_q;
      op_size_d    = op_size_q;
      op_signed_d  = op_signed_q;
      op_addr_d    = op_addr_q;
      op_wdata_d   = op_wdata_q;
      wbuf_d       = wbuf_q;
      resp_valid_d = 1'b0;
      resp_rdata_d = 32'h0;
      resp_err_d   = 1'b0;
      mem_we       = 1'b0;
      mem_a        = 32'h0;
      mem_wd       = 32'h0;

      case (state_q)
         IDLE: begin
            if (accept) begin
               op_we_d     = req_we;
               op_size_d   = req_size;
               op_signed_d = req_signed;
               op_addr_d   = req_addr;
               op_wdata_d  = req_wdata;
               if (req_bad)                 state_d = ERR;
               else if (!req_we)            state_d = LOAD;
               else if (req_size == SZ_WORD) state_d = STORE;
               else                         state_d = RMW_RD;
            end
         end
         LOAD: begin
            mem_a        = aligned_a;
            resp_valid_d = 1'b1;
            resp_rdata_d = load_data;
            state_d      = IDLE;
         end
         STORE: begin
            mem_we       = 1'b1;
            mem_a        = aligned_a;
            mem_wd       = op_wdata_q;
            resp_valid_d = 1'b1;
            state_d      = IDLE;
         end
         RMW_RD: begin
            mem_a   = aligned_a;
            wbuf_d  = merge_data;
            state_d = RMW_WR;
         end
         RMW_WR: begin
            mem_we       = 1'b1;
            mem_a        = aligned_a;
            mem_wd       = wbuf_q;
            resp_valid_d = 1'b1;
            state_d      = IDLE;
         end
         ERR: begin
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            state_d      = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         op_we_q      <= 1'b0;
         op_size_q    <= SZ_BYTE;
         op_signed_q  <= 1'b0;
         op_addr_q    <= 32'h0;
         op_wdata_q   <= 32'h0;
         wbuf_q       <= 32'h0;
         resp_valid_q <= 1'b0;
         resp_rdata_q <= 32'h0;
         resp_err_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         op_we_q      <= op_we_d;
         op_size_q    <= op_size_d;
         op_signed_q  <= op_signed_d;
         op_addr_q    <= op_addr_d;
         op_wdata_q   <= op_wdata_d;
         wbuf_q       <= wbuf_d;
         resp_valid_q <= resp_valid_d;
         resp_rdata_q <= resp_rdata_d;
         resp_err_q   <= resp_err_d;
      end
   end

   // Store direction is fully implied by the state, so op_we_q only documents the request.
   assign resp_valid = resp_valid_q;
   assign resp_rdata = resp_rdata_q | {32{1'b0 & op_we_q}};
   assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_dmem_lsu.sv
// Self-checking bench for dmem_lsu: directed scenarios plus randomized accesses
// compared against a byte-array reference model of data memory.
module tb_dmem_lsu;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [1:0]  req_size;
   logic        req_signed;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic        stall;
   logic        mem_we;
   logic [31:0] mem_a;
   logic [31:0] mem_wd;
   logic [31:0] mem_rd;

   int checks = 0;
   int errors = 0;

   logic [31:0] dmem [64];
   bit          mem_clr = 1'b1;
   int          we_total = 0;
   logic [31:0] last_wa = 32'h0;
   logic [31:0] last_wd = 32'h0;

   logic [7:0]  ref_mem [256];
   logic [31:0] exp_q [$];

   always #5 clk = ~clk;

   dmem_lsu #(.MEM_WORDS(64), .DATA_W(32)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_size   (req_size),
      .req_signed (req_signed),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .resp_valid (resp_valid),
      .resp_rdata (resp_rdata),
      .resp_err   (resp_err),
      .stall      (stall),
      .mem_we     (mem_we),
      .mem_a      (mem_a),
      .mem_wd     (mem_wd),
      .mem_rd     (mem_rd)
   );

   // Data memory: combinational read, synchronous write.
   assign mem_rd = dmem[mem_a[7:2]];

   always @(posedge clk) begin
      if (mem_clr) begin
         for (int i = 0; i < 64; i++) dmem[i] <= 32'h0;
      end else if (mem_we) begin
         dmem[mem_a[7:2]] <= mem_wd;
         we_total <= we_total + 1;
         last_wa  <= mem_a;
         last_wd  <= mem_wd;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic ref_err(logic [1:0] sz, logic [31:0] a);
      logic e;
      e = (sz == 2'b11) || (a >= 32'd256);
`ifdef DMEM_LSU_MISALIGN_TRAP_EN
      if (sz == 2'b01 && a[0]) e = 1'b1;
      if (sz == 2'b10 && a[1:0] != 2'b00) e = 1'b1;
`endif
      return e;
   endfunction

   function automatic logic [31:0] ref_load(logic [1:0] sz, logic sgn, logic [31:0] a);
      int base;
      int v;
      base = int'(a[7:0]);
      if (sz == 2'b00) begin
         v = int'(ref_mem[base]);
         if (sgn && v >= 128) v = v - 256;
      end else if (sz == 2'b01) begin
         base = base & ~1;
         v = int'(ref_mem[base]) + 256 * int'(ref_mem[base+1]);
         if (sgn && v >= 32768) v = v - 65536;
      end else begin
         base = base & ~3;
         v = int'(ref_mem[base]) + 256 * int'(ref_mem[base+1]) +
             65536 * int'(ref_mem[base+2]) + 16777216 * int'(ref_mem[base+3]);
      end
      return 32'(v);
   endfunction

   task automatic ref_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
      int base;
      base = int'(a[7:0]);
      if (sz == 2'b00) begin
         ref_mem[base] = wd[7:0];
      end else if (sz == 2'b01) begin
         base = base & ~1;
         ref_mem[base]   = wd[7:0];
         ref_mem[base+1] = wd[15:8];
      end else begin
         base = base & ~3;
         for (int k = 0; k < 4; k++) ref_mem[base+k] = wd[8*k +: 8];
      end
   endtask

   logic [31:0] first_a;
   logic        first_we;

   task automatic xact(input logic we, input logic [1:0] sz, input logic sgn,
                       input logic [31:0] a, input logic [31:0] wd,
                       output logic [31:0] rd, output logic er);
      int          n;
      int          cyc;
      int          we_base;
      int          exp_lat;
      logic        exp_e;
      logic [31:0] exp_d;
      exp_e = ref_err(sz, a);
      exp_d = (we || exp_e) ? 32'h0 : ref_load(sz, sgn, a);
      exp_q.push_back(exp_d);
      exp_lat = (we && !exp_e && sz != 2'b10) ? 3 : 2;
      @(negedge clk);
      req_valid  = 1'b1;
      req_we     = we;
      req_size   = sz;
      req_signed = sgn;
      req_addr   = a;
      req_wdata  = wd;
      n = 0;
      while (!req_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("ready_wait", 32'(n < 20), 32'd1);
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      we_base   = we_total;
      first_a   = mem_a;
      first_we  = mem_we;
      cyc = 1;
      while (!resp_valid && cyc < 10) begin
         check("busy_stall", 32'(stall), 32'd1);
         @(posedge clk);
         #1;
         cyc++;
      end
      rd = resp_rdata;
      er = resp_err;
      check("latency", 32'(cyc), 32'(exp_lat));
      check("resp_err", 32'(resp_err), 32'(exp_e));
      check("resp_rdata", resp_rdata, exp_q.pop_front());
      check("we_pulses", 32'(we_total - we_base), (we && !exp_e) ? 32'd1 : 32'd0);
      if (we && !exp_e) begin
         check("write_addr", last_wa, a & ~32'h3);
         ref_store(sz, a, wd);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] rd;
      logic        er;
      int          we_base;
      for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
      rst_n = 1'b0;
      req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_signed = 1'b0;
      req_addr = 32'h0; req_wdata = 32'h0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_ready", 32'(req_ready), 32'd1);
      check("rst_stall", 32'(stall), 32'd0);
      check("rst_resp_valid", 32'(resp_valid), 32'd0);
      check("rst_resp_err", 32'(resp_err), 32'd0);
      check("rst_resp_rdata", resp_rdata, 32'h0);
      check("rst_mem_we", 32'(mem_we), 32'd0);
      check("rst_mem_a", mem_a, 32'h0);
      check("rst_mem_wd", mem_wd, 32'h0);
      mem_clr = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;

      // Word store then word load.
      xact(1'b1, 2'b10, 1'b0, 32'h4, 32'h11223344, rd, er);
      check("sw_wa", last_wa, 32'h4);
      check("sw_wd", last_wd, 32'h11223344);
      xact(1'b0, 2'b10, 1'b0, 32'h4, 32'h0, rd, er);
      check("lw4", rd, 32'h11223344);

      // Byte store goes through read-modify-write.
      xact(1'b1, 2'b00, 1'b0, 32'h5, 32'hFFFFFFAB, rd, er);
      check("sb_rd_a", first_a, 32'h4);
      check("sb_rd_we", 32'(first_we), 32'd0);
      check("sb_wd", last_wd, 32'h1122AB44);

      xact(1'b0, 2'b00, 1'b1, 32'h5, 32'h0, rd, er);
      check("lb5", rd, 32'hFFFFFFAB);
      xact(1'b0, 2'b00, 1'b0, 32'h5, 32'h0, rd, er);
      check("lbu5", rd, 32'h000000AB);
      xact(1'b0, 2'b01, 1'b1, 32'h6, 32'h0, rd, er);
      check("lh6", rd, 32'h00001122);
      xact(1'b0, 2'b01, 1'b0, 32'h4, 32'h0, rd, er);
      check("lhu4", rd, 32'h0000AB44);

      xact(1'b0, 2'b10, 1'b0, 32'h6, 32'h0, rd, er);
`ifdef DMEM_LSU_MISALIGN_TRAP_EN
      check("lw6_err", 32'(er), 32'd1);
      check("lw6_data", rd, 32'h0);
`else
      check("lw6_a", first_a, 32'h4);
      check("lw6_data", rd, 32'h1122AB44);
`endif
      xact(1'b0, 2'b11, 1'b0, 32'h4, 32'h0, rd, er);
      check("size3_err", 32'(er), 32'd1);
      xact(1'b1, 2'b10, 1'b0, 32'h100, 32'hDEADBEEF, rd, er);
      check("oob_err", 32'(er), 32'd1);

      // Back-to-back with req_valid held high.
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_signed = 1'b0;
      req_addr = 32'h8; req_wdata = 32'hCAFEF00D;
      @(posedge clk);
      #1;
      ref_store(2'b10, 32'h8, 32'hCAFEF00D);
      req_we = 1'b0; req_wdata = 32'h0;
      @(posedge clk);
      #1;
      check("b2b_resp1", 32'(resp_valid), 32'd1);
      check("b2b_ready1", 32'(req_ready), 32'd1);
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      check("b2b_busy2", 32'(stall), 32'd1);
      @(posedge clk);
      #1;
      check("b2b_resp2", 32'(resp_valid), 32'd1);
      check("b2b_data", resp_rdata, 32'hCAFEF00D);
      check("b2b_err", 32'(resp_err), 32'd0);

      // Reset during RMW_RD drops the halfword store.
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_size = 2'b01; req_addr = 32'h8; req_wdata = 32'h0000BEEF;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      we_base = we_total;
      check("rmw_rd_a", mem_a, 32'h8);
      check("rmw_rd_we", 32'(mem_we), 32'd0);
      #2;
      rst_n = 1'b0;
      #1;
      check("rst_mid_we", 32'(mem_we), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("rel_ready", 32'(req_ready), 32'd1);
      check("rel_resp_valid", 32'(resp_valid), 32'd0);
      check("rel_stall", 32'(stall), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      check("rel_no_resp", 32'(resp_valid), 32'd0);
      check("rel_no_write", 32'(we_total - we_base), 32'd0);
      xact(1'b0, 2'b10, 1'b0, 32'h8, 32'h0, rd, er);
      check("rst_word8", rd, 32'hCAFEF00D);

      // Randomized mix, including illegal sizes and out-of-range addresses.
      for (int t = 0; t < 80; t++) begin
         xact(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
              32'($urandom_range(0, 271)), $urandom, rd, er);
      end

      for (int i = 0; i < 64; i++) begin
         check("mem_image", dmem[i], {ref_mem[4*i+3], ref_mem[4*i+2], ref_mem[4*i+1], ref_mem[4*i]});
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
